// File: rtl/jtframe_sdram_rq_pkg.sv
// rtl/jtframe_sdram_rq_pkg.sv - shared widths, data_read half ordering and FSM encoding for jtframe_sdram_rq
package jtframe_sdram_pkg;
  localparam int ADDR_W = 22;
  localparam int BANK_W = 2;
  localparam int TAG_W  = ADDR_W - 1;
  // data_read carries the even word in the low half and the odd word in the high half
  localparam int EVEN_LSB = 0;
  localparam int ODD_LSB  = 16;

  typedef enum logic [1:0] { ST_IDLE, ST_REQ, ST_WAIT } rq_state_t;
endpackage

// File: rtl/jtframe_sdram_rq_if.sv
// rtl/jtframe_sdram_rq_if.sv - requester <-> SDRAM controller game-port handshake bundle
interface jtframe_sdram_rq_if;
  import jtframe_sdram_pkg::*;

  logic              read_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic              sdram_rnw;
  logic [1:0]        sdram_wrmask;
  logic [15:0]       data_write;
  logic              sdram_ack;
  logic              data_rdy;
  logic [31:0]       data_read;

  modport master (
    output read_req, sdram_addr, sdram_bank, sdram_rnw, sdram_wrmask, data_write,
    input  sdram_ack, data_rdy, data_read
  );
  modport slave (
    input  read_req, sdram_addr, sdram_bank, sdram_rnw, sdram_wrmask, data_write,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jtframe_sdram_rq_cache.sv
// rtl/jtframe_sdram_rq_cache.sv - 2-entry line cache with round-robin replacement and invalidation
module jtframe_sdram_rq_cache
  import jtframe_sdram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             inv_all,
  input  logic             inv_one,
  input  logic [TAG_W-1:0] inv_tag,
  input  logic             fill,
  input  logic             fill_valid,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data
);
  logic [1:0]       valid;
  logic [TAG_W-1:0] tag  [2];
  logic [31:0]      data [2];
  logic             lru;

  always_comb begin
    hit      = 1'b0;
    hit_data = data[0];
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && tag[i] == lookup_tag) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

  // the pointer advances on every fill, including fills that land invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      lru   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (inv_all) begin
        valid <= '0;
      end else if (inv_one) begin
        for (int i = 0; i < 2; i++)
          if (tag[i] == inv_tag) valid[i] <= 1'b0;
      end
      if (fill) begin
        valid[lru] <= fill_valid;
        tag[lru]   <= fill_tag;
        data[lru]  <= fill_data;
        lru        <= ~lru;
      end
    end
  end
endmodule

// File: rtl/jtframe_sdram_rq.sv
// rtl/jtframe_sdram_rq.sv - cached ROM read requester for the SDRAM game port
// Optional writes enabled by defining JTFRAME_SDRAM_RQ_WRITE_EN.
module jtframe_sdram_rq
  import jtframe_sdram_pkg::*;
#(
  parameter int                AW     = 18,
  parameter int                DW     = 16,
  parameter logic [ADDR_W-1:0] OFFSET = 22'h0,
  parameter logic [BANK_W-1:0] BANK   = 2'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          game_cs,
  input  logic [AW-1:0] game_addr,
  output logic [DW-1:0] game_dout,
  output logic          game_ok,
  input  logic          clr,
  input  logic          game_we,
  input  logic [15:0]   game_din,
  input  logic [1:0]    game_wrmask,
  input  logic          loop_rst,
  jtframe_sdram_rq_if.master sdram
);
  rq_state_t         state, next;
  logic [ADDR_W-1:0] ga, wa, wsum, la, addr_r;
  logic [AW-1:0]     req_game, ok_addr;
  logic [DW-1:0]     dout_r;
  logic [31:0]       hit_data;
  logic              hit, hit_ok, inv, req_r, ok_r, clr_seen;
  logic              launch_rd, launch_wr, done, we_go, is_wr, wr_pulse;

  function automatic logic [DW-1:0] pick(input logic [31:0] line, input logic [AW-1:0] a);
    logic [31:0] sh;
    case (DW)
      8:       sh = line >> {a[1:0], 3'b000};
      16:      sh = a[0] ? (line >> ODD_LSB) : (line >> EVEN_LSB);
      default: sh = line;
    endcase
    return sh[DW-1:0];
  endfunction

  assign ga = ADDR_W'(game_addr);
  always_comb begin
    case (DW)
      8:       wa = ga >> 1;
      32:      wa = ga << 1;
      default: wa = ga;
    endcase
  end
  assign wsum   = wa + OFFSET;
  assign la     = {wsum[ADDR_W-1:1], 1'b0};
  assign inv    = clr | loop_rst;
  assign hit_ok = game_cs && hit && !inv;

  jtframe_sdram_rq_cache u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (la[ADDR_W-1:1]),
    .hit        (hit),
    .hit_data   (hit_data),
    .inv_all    (inv),
    .inv_one    (launch_wr),
    .inv_tag    (wsum[ADDR_W-1:1]),
    .fill       (done && !is_wr),
    .fill_valid (!clr_seen && !inv),
    .fill_tag   (addr_r[ADDR_W-1:1]),
    .fill_data  (sdram.data_read)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (we_go) begin
          launch_wr = 1'b1;
          next      = ST_REQ;
        end else if (game_cs && !hit_ok && !loop_rst) begin
          launch_rd = 1'b1;
          next      = ST_REQ;
        end
      end
      ST_REQ:  if (sdram.sdram_ack) next = ST_WAIT;
      ST_WAIT: if (sdram.data_rdy) begin
        done = 1'b1;
        next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  // a clr seen while a fill is outstanding poisons that fill and suppresses its game_ok
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r    <= 1'b0;
      addr_r   <= '0;
      req_game <= '0;
      clr_seen <= 1'b0;
      ok_r     <= 1'b0;
      ok_addr  <= '0;
      dout_r   <= '0;
    end else begin
      if (launch_rd || launch_wr) begin
        req_r    <= 1'b1;
        addr_r   <= launch_wr ? wsum : la;
        req_game <= game_addr;
        clr_seen <= 1'b0;
        ok_r     <= 1'b0;
      end else if (state == ST_REQ && sdram.sdram_ack) begin
        req_r <= 1'b0;
      end
      if (state != ST_IDLE && inv) clr_seen <= 1'b1;
      if (done) begin
        ok_r    <= !is_wr && !clr_seen && !inv;
        ok_addr <= req_game;
        dout_r  <= pick(sdram.data_read, req_game);
      end else if (state == ST_IDLE && !launch_rd && !launch_wr) begin
        ok_r <= hit_ok;
        if (hit_ok) begin
          ok_addr <= game_addr;
          dout_r  <= pick(hit_data, game_addr);
        end
      end
    end
  end

`ifdef JTFRAME_SDRAM_RQ_WRITE_EN
  logic        rnw_r;
  logic [15:0] wdata_r;
  logic [1:0]  wmask_r;
  assign we_go = game_we && (DW == 16) && !loop_rst;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnw_r    <= 1'b1;
      is_wr    <= 1'b0;
      wr_pulse <= 1'b0;
      wdata_r  <= '0;
      wmask_r  <= '0;
    end else begin
      wr_pulse <= done && is_wr;
      if (launch_wr) begin
        rnw_r   <= 1'b0;
        is_wr   <= 1'b1;
        wdata_r <= game_din;
        wmask_r <= game_wrmask;
      end else if (launch_rd) begin
        rnw_r   <= 1'b1;
        is_wr   <= 1'b0;
        wmask_r <= '0;
      end
    end
  end
  assign sdram.sdram_rnw    = rnw_r;
  assign sdram.data_write   = wdata_r;
  assign sdram.sdram_wrmask = wmask_r;
`else
  logic unused_wr;
  assign unused_wr          = ^{game_we, game_din, game_wrmask, wsum[0]};
  assign we_go              = 1'b0;
  assign is_wr              = 1'b0;
  assign wr_pulse           = 1'b0;
  assign sdram.sdram_rnw    = 1'b1;
  assign sdram.data_write   = '0;
  assign sdram.sdram_wrmask = '0;
`endif

  assign sdram.read_req   = req_r;
  assign sdram.sdram_addr = addr_r;
  assign sdram.sdram_bank = BANK;
  assign game_dout        = dout_r;
  assign game_ok          = (ok_r && game_cs && game_addr == ok_addr) || wr_pulse;
endmodule

// File: tb/tb_jtframe_sdram_rq.sv
// tb/tb_jtframe_sdram_rq.sv - directed and randomized checks of jtframe_sdram_rq against a line-cache model
module tb_jtframe_sdram_rq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cs = 1'b0, clr = 1'b0, loop_rst = 1'b0, we = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] din = '0, dout;
  logic [1:0]  wmask = '0;
  logic        ok;
  logic        cs8 = 1'b0, clr8 = 1'b0, ok8;
  logic [17:0] addr8 = '0;
  logic [7:0]  dout8;

  always #5 clk = ~clk;

  jtframe_sdram_rq_if sif ();
  jtframe_sdram_rq_if sif8 ();

  jtframe_sdram_rq #(.AW(18), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .game_cs(cs), .game_addr(addr), .game_dout(dout),
    .game_ok(ok), .clr(clr), .game_we(we), .game_din(din), .game_wrmask(wmask),
    .loop_rst(loop_rst), .sdram(sif)
  );

  jtframe_sdram_rq #(.AW(18), .DW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .game_cs(cs8), .game_addr(addr8), .game_dout(dout8),
    .game_ok(ok8), .clr(clr8), .game_we(we), .game_din(din), .game_wrmask(wmask),
    .loop_rst(loop_rst), .sdram(sif8)
  );

  int total = 0, bad = 0;

  // Reference: word-addressed memory plus a 2-line cache filled in arrival order
  typedef struct { bit v; int line; } ent_t;
  ent_t cq[$];
  logic [15:0] mem [int];

  function automatic logic [15:0] rd(int w);
    if (mem.exists(w)) return mem[w];
    return 16'((w * 40503) ^ 32'h3C5A);
  endfunction

  function automatic bit m_hit(int line);
    foreach (cq[i]) if (cq[i].v && cq[i].line == line) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fill(int line, bit v);
    ent_t e;
    e.v = v;
    e.line = line;
    cq.push_back(e);
    if (cq.size() > 2) void'(cq.pop_front());
  endtask

  task automatic m_clear();
    foreach (cq[i]) cq[i].v = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(int la, int delay);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("req_hold", sif.read_req, 1);
      chk("addr_hold", sif.sdram_addr, la);
    end
    sif.sdram_ack = 1'b1;
    tick();
    sif.sdram_ack = 1'b0;
    chk("req_drop", sif.read_req, 0);
    sif.data_read = {rd(la + 1), rd(la)};
    sif.data_rdy = 1'b1;
    tick();
    sif.data_rdy = 1'b0;
    m_fill(la, 1'b1);
  endtask

  task automatic serve(int la, int delay);
    tick();
    chk("req_up", sif.read_req, 1);
    chk("req_addr", sif.sdram_addr, la);
    chk("req_rnw", sif.sdram_rnw, 1);
    complete(la, delay);
  endtask

  task automatic access(int a, int delay);
    int la = a & ~1;
    bit h = m_hit(la);
    cs = 1'b1;
    if (18'(a) != addr) begin
      addr = 18'(a);
      #1 chk("ok_drop", ok, 0);
    end
    if (h) begin
      tick();
      chk("hit_noreq", sif.read_req, 0);
    end else begin
      serve(la, delay);
    end
    chk("ok", ok, 1);
    chk("dout", dout, rd(a));
  endtask

  initial begin
    sif.sdram_ack = 1'b0;  sif.data_rdy = 1'b0;  sif.data_read = '0;
    sif8.sdram_ack = 1'b0; sif8.data_rdy = 1'b0; sif8.data_read = '0;
    mem[32'h100] = 16'hCAFE;
    mem[32'h101] = 16'hBEEF;

    #12;
    chk("rst_req", sif.read_req, 0);
    chk("rst_addr", sif.sdram_addr, 0);
    chk("rst_rnw", sif.sdram_rnw, 1);
    chk("rst_mask", sif.sdram_wrmask, 0);
    chk("rst_wdata", sif.data_write, 0);
    chk("rst_bank", sif.sdram_bank, 0);
    chk("rst_ok", ok, 0);
    chk("rst_dout", dout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // byte-wide port: 0x203 maps to line 0x100, byte 3
    cs8 = 1'b1;
    addr8 = 18'h203;
    tick();
    chk("b_req", sif8.read_req, 1);
    chk("b_addr", sif8.sdram_addr, 32'h100);
    sif8.sdram_ack = 1'b1;
    tick();
    sif8.sdram_ack = 1'b0;
    sif8.data_read = 32'h4433_2211;
    sif8.data_rdy = 1'b1;
    tick();
    sif8.data_rdy = 1'b0;
    chk("b_ok", ok8, 1);
    chk("b_dout", dout8, 8'h44);
    addr8 = 18'h200;
    #1 chk("b_ok_drop", ok8, 0);
    tick();
    chk("b_hit_ok", ok8, 1);
    chk("b_hit_dout", dout8, 8'h11);
    chk("b_hit_noreq", sif8.read_req, 0);
    cs8 = 1'b0;

    // miss then hit in the same line
    access(32'h100, 2);
    access(32'h101, 0);
    cs = 1'b0;
    #1 chk("cs_drop", ok, 0);

    // round-robin eviction
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear();
    access(0, 1);
    access(2, 0);
    access(4, 0);
    access(0, 0);

    // long ack delay
    access(32'h300, 20);

    // clr during WAIT poisons the fill
    addr = 18'h40;
    tick();
    chk("cw_req", sif.read_req, 1);
    sif.sdram_ack = 1'b1;
    tick();
    sif.sdram_ack = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear();
    sif.data_read = {rd(32'h41), rd(32'h40)};
    sif.data_rdy = 1'b1;
    tick();
    sif.data_rdy = 1'b0;
    m_fill(32'h40, 1'b0);
    chk("cw_ok", ok, 0);
    serve(32'h40, 0);
    chk("cw_reok", ok, 1);
    chk("cw_dout", dout, rd(32'h40));

    // clr beats a hit in the same cycle
    addr = 18'h41;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear();
    chk("ch_req", sif.read_req, 1);
    chk("ch_ok", ok, 0);
    complete(32'h40, 1);
    chk("ch_reok", ok, 1);
    chk("ch_dout", dout, rd(32'h41));

    // no requests while the controller initialises
    loop_rst = 1'b1;
    addr = 18'h500;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("loop_noreq", sif.read_req, 0);
    end
    m_clear();
    loop_rst = 1'b0;
    serve(32'h500, 0);
    chk("loop_ok", ok, 1);
    chk("loop_dout", dout, rd(32'h500));

    for (int n = 0; n < 40; n++)
      access(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    // reset while a request is outstanding
    addr = 18'h600;
    tick();
    chk("rr_req", sif.read_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rr_req_drop", sif.read_req, 0);
    chk("rr_ok", ok, 0);
    chk("rr_dout", dout, 0);
    cs = 1'b0;
    cq.delete();
    tick();
    rst_n = 1'b1;
    sif.data_read = 32'hDEAD_BEEF;
    sif.data_rdy = 1'b1;
    tick();
    sif.data_rdy = 1'b0;
    tick();
    chk("stray_ok", ok, 0);
    chk("stray_req", sif.read_req, 0);
    access(3, 0);
    access(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
